// File: rtl/sevenseg_scan_if.sv
// sevenseg_scan_if: host-side data and display-pin bundle for the multiplexed seven-segment driver
interface sevenseg_scan_if #(parameter int NUM_DIGITS = 4);
    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    frame_done;
    modport master (
        output en, load, value, dp_in, blank_mask, blink_mask,
        input  seg_out, dp_out, dig_sel, frame_done
    );
    modport slave (
        input  en, load, value, dp_in, blank_mask, blink_mask,
        output seg_out, dp_out, dig_sel, frame_done
    );
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: double-buffered N-digit hex display multiplexer with dp, blank, blink and polarity control
module sevenseg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input logic            clk,
    input logic            rst,
    sevenseg_scan_if.slave bus
);
    localparam int   IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int   PW = $clog2(SCAN_DIV);
    localparam int   FW = $clog2(BLINK_FRAMES + 1);
    localparam logic SP = SEG_ACTIVE_LOW != 0;
    localparam logic DP = DIG_ACTIVE_LOW != 0;
    localparam logic [15:0][6:0] HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx;
    logic [FW-1:0]                fcnt;
    logic                         phase;
    logic [NUM_DIGITS-1:0][3:0]   pv, dv;
    logic [NUM_DIGITS-1:0]        pdp, ddp, pbl, dbl, pbk, dbk;
    logic                         tc, fend, dark;
    logic [6:0]                   seg_n;

    // slot terminal count, frame end and per-digit darkening for the digit currently indexed
    always_comb begin
        tc    = presc == PW'(SCAN_DIV - 1);
        fend  = bus.en && tc && idx == IW'(NUM_DIGITS - 1);
        dark  = dbl[idx] | (dbk[idx] & phase) | ~bus.en;
        seg_n = dark ? 7'd0 : HEX[dv[idx]];
    end

    // prescaler, digit index and blink timing all freeze while the display is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (bus.en) begin
            presc <= tc ? '0 : presc + 1'b1;
            if (tc)
                idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
            if (fend) begin
                fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
                if (fcnt == FW'(BLINK_FRAMES - 1))
                    phase <= ~phase;
            end
        end
    end

    // pending buffer takes every load; display buffer swaps only at frame end, bypassing a coincident load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {pv, pdp, pbl, pbk} <= '0;
            {dv, ddp, dbl, dbk} <= '0;
        end else begin
            if (bus.load)
                {pv, pdp, pbl, pbk} <= {bus.value, bus.dp_in, bus.blank_mask, bus.blink_mask};
            if (fend)
                {dv, ddp, dbl, dbk} <= bus.load ? {bus.value, bus.dp_in, bus.blank_mask, bus.blink_mask}
                                                : {pv, pdp, pbl, pbk};
        end
    end

    // registered pins so segments and digit select always switch on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg_out    <= {7{SP}};
            bus.dp_out     <= SP;
            bus.dig_sel    <= {NUM_DIGITS{DP}};
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg_out    <= seg_n ^ {7{SP}};
            bus.dp_out     <= (~dark & ddp[idx]) ^ SP;
            bus.dig_sel    <= (bus.en ? NUM_DIGITS'(1) << idx : '0) ^ {NUM_DIGITS{DP}};
            bus.frame_done <= fend;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: random and directed stimulus against an arithmetic model of the scanned display
module tb_sevenseg_scan;
    localparam int N  = 4;
    localparam int S  = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sevenseg_scan_if #(.NUM_DIGITS(N)) bus ();

    sevenseg_scan #(
        .NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_FRAMES(BF),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int         n;
    int         md, mph;
    logic       mdk;
    logic [15:0] pv, dv;
    logic [3:0]  pdp, ddp, pbl, dbl, pbk, dbk;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  e_dig;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // model: n counts enabled cycles, so slot, digit, frame and blink phase follow by division
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            {pv, pdp, pbl, pbk} = '0;
            {dv, ddp, dbl, dbk} = '0;
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_fd = 1'b0;
        end else begin
            md  = (n / S) % N;
            mph = (n / (S * N * BF)) % 2;
            mdk = dbl[md] | (dbk[md] & mph[0]) | !bus.en;
            e_seg = mdk ? 7'h7F : ~hex_tab[dv[4*md +: 4]];
            e_dp  = mdk ? 1'b1 : ~ddp[md];
            e_dig = bus.en ? ~(4'b0001 << md) : 4'hF;
            e_fd  = 1'b0;
            if (bus.en) begin
                if ((n + 1) % (S * N) == 0) begin
                    e_fd = 1'b1;
                    if (bus.load) {dv, ddp, dbl, dbk} = {bus.value, bus.dp_in, bus.blank_mask, bus.blink_mask};
                    else          {dv, ddp, dbl, dbk} = {pv, pdp, pbl, pbk};
                end
                n++;
            end
            if (bus.load) {pv, pdp, pbl, pbk} = {bus.value, bus.dp_in, bus.blank_mask, bus.blink_mask};
        end
    end

    // every-cycle comparison of all pins against the model
    always @(negedge clk) begin
        check("seg", bus.seg_out, e_seg);
        check("dp", bus.dp_out, e_dp);
        check("dig", bus.dig_sel, e_dig);
        check("frame_done", bus.frame_done, e_fd);
    end

    task automatic wait_fd();
        logic found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = bus.frame_done;
        end
        check("fd_wait", found, 1'b1);
    endtask

    task automatic slots(input logic [3:0][6:0] sv);
        logic [3:0] ed;
        wait_fd();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            ed = ~(4'b0001 << k);
            check("lit_dig", bus.dig_sel, ed);
            check("lit_seg", bus.seg_out, sv[k]);
            repeat (S) @(negedge clk);
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl, input logic [3:0] bk);
        bus.value = v; bus.dp_in = dp; bus.blank_mask = bl; bus.blink_mask = bk; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        int cnt, cdark, cdp;
        bus.en = 1'b0; bus.load = 1'b0; bus.value = '0;
        bus.dp_in = '0; bus.blank_mask = '0; bus.blink_mask = '0;
        @(negedge clk);
        check("rst_seg", bus.seg_out, 7'h7F);
        check("rst_dig", bus.dig_sel, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
        load(16'h3210, 4'h0, 4'h0, 4'h0);
        slots({7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000});
        load(16'hFEDC, 4'h0, 4'h0, 4'h0);
        slots({7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110});
        load(16'hBA98, 4'h0, 4'h0, 4'h0);
        slots({7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000});
        cnt = 0;
        repeat (160) begin
            @(negedge clk);
            cnt += int'(bus.frame_done);
        end
        check("fd_count", cnt, 10);
        load(16'h0000, 4'b0100, 4'b0000, 4'b0010);
        wait_fd();
        cdark = 0; cdp = 0;
        repeat (128) begin
            @(negedge clk);
            cdark += int'(bus.dig_sel == 4'b1101 && bus.seg_out == 7'h7F);
            cdp   += int'(bus.dp_out == 1'b0);
        end
        check("blink_dark", cdark, 16);
        check("dp_slots", cdp, 32);
        repeat (2) @(negedge clk);
        bus.en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("off_dig", bus.dig_sel, 4'hF);
            check("off_seg", bus.seg_out, 7'h7F);
        end
        bus.en = 1'b1;
        repeat (37) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_seg", bus.seg_out, 7'h7F);
        check("arst_dp", bus.dp_out, 1'b1);
        check("arst_dig", bus.dig_sel, 4'hF);
        check("arst_fd", bus.frame_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        slots({7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        repeat (1500) begin
            @(negedge clk);
            bus.load       = $urandom_range(0, 9) == 0;
            bus.value      = 16'($urandom);
            bus.dp_in      = 4'($urandom);
            bus.blank_mask = 4'($urandom & $urandom);
            bus.blink_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) bus.en = ~bus.en;
        end
        bus.load = 1'b0;
        bus.en = 1'b1;
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Parametrised multiplexed seven-segment display driver, the multi-digit successor to the team's single-digit decoder. It holds an N-digit hexadecimal value in a double-buffered register and time-multiplexes the digits onto one shared segment bus. It adds per-digit decimal point, blanking and blink, plus selectable output polarity. It sits between the system registers and the board's common-anode or common-cathode display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (legal range 1..8).
SCAN_DIV, 1000, clk cycles per digit slot (must be >= 2).
BLINK_FRAMES, 64, full scan frames per blink half-period (must be >= 1).
SEG_ACTIVE_LOW, 1, 1 = a lit segment or dp drives 0; 0 = a lit segment drives 1.
DIG_ACTIVE_LOW, 1, 1 = the selected digit drives 0; 0 = the selected digit drives 1.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  display enable; 0 = all segments and digits inactive.
load  in  1  one-cycle strobe that captures value, dp_in, blank_mask and blink_mask into the pending buffer.
value  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k (digit 0 = least significant).
dp_in  in  NUM_DIGITS  decimal point request per digit.
blank_mask  in  NUM_DIGITS  1 = digit k is dark.
blink_mask  in  NUM_DIGITS  1 = digit k blinks.
seg_out  out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW.
dp_out  out  1  decimal point, same polarity as seg_out.
dig_sel  out  NUM_DIGITS  one-hot digit enable, polarity set by DIG_ACTIVE_LOW.
frame_done  out  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Reset (asynchronous, in any state): prescaler=0, digit index=0, blink_phase=0, pending and display buffers all zero.
- Outputs while in reset: seg_out and dp_out at the unlit level, dig_sel all inactive, frame_done=0.
- Prescaler: counts 0..SCAN_DIV-1 while en=1. At terminal count it wraps to 0 and the digit index advances.
- Digit index: advances k -> k+1; NUM_DIGITS-1 wraps to 0.
- Frame end: the wrap from NUM_DIGITS-1 to 0 is the frame end. frame_done pulses high for the cycle after that wrap.
- Blink: a frame counter counts frame ends. Every BLINK_FRAMES frames, blink_phase toggles and the counter clears.
- Double buffering: load writes the pending buffer. At frame end, the display buffer takes the pending buffer contents.
- Load coinciding with frame end: the new input data goes straight into both buffers. No frame ever shows mixed old and new digits.
- Decode, active-high pattern gfedcba, inverted when SEG_ACTIVE_LOW=1:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Digit k is dark when any of these holds: blank_mask[k]=1; blink_mask[k]=1 and blink_phase=1; en=0. A dark digit drives all segments and dp unlit. Its dig_sel bit still follows the scan unless en=0.
- Output timing: seg_out, dp_out and dig_sel are registered. They reflect the new digit index one cycle after the index changes. Segments and digit select always change on the same edge.
- en=0: prescaler, index, blink counter and blink_phase hold their values. All outputs go inactive one cycle later. load still updates the pending buffer. On en returning to 1, scanning resumes from the held index.
- NUM_DIGITS=1: the index is a constant 0, so every prescaler wrap is a frame end.

Test Plan:
Setup for all scenarios unless stated: NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, both polarities active-low.
- Reset then en=1, load value=16'h3210, masks all 0 -> after the first frame end, dig_sel cycles 1110,1101,1011,0111 every 4 clks, and seg_out shows 1000000,1111001,0100100,0110000 in that order.
- Hex coverage: load value=16'hFEDC, then value=16'hBA98 -> seg_out shows patterns 0001110,0000110,0100001,1000110 for F,E,d,C, then 0000011,0001000,0010000,0000000 for b,A,9,8.
- Load mid-frame (cycle 5 of a frame) -> the rest of that frame still shows old digits; new digits appear from digit 0 of the next frame; frame_done is high exactly 1 cycle per 16 clks.
- blink_mask=4'b0010, dp_in=4'b0100 -> digit 1 is unlit (seg_out=1111111) on alternating 2-frame windows; dp_out=0 only in digit 2's slot.
- en dropped mid-slot for 10 clks -> dig_sel=1111 and seg_out=1111111 throughout; scanning resumes at the same digit with the prescaler preserved.
- Assert rst asynchronously mid-scan (between clk edges) -> outputs go inactive immediately; after release, scanning restarts at digit 0 showing 0000.
